// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronises the raw lines, decodes 11-bit frames and
// buffers received bytes in a FWFT FIFO. Define PS2_RX_TIMEOUT_EN to abort stalled frames.
module ps2_rx_fifo #(
    parameter int SYNC_STAGES    = 2,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Line synchronisers reset to 1 so a reset never manufactures a falling edge.
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   data_s;
    logic                   fall;

    // NOTE: sequential state is always assigned with <= so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_s;
        end
    end

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    assign fall   = clk_prev & ~clk_s;

    state_t     state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift, shift_n;
    logic       par_acc, par_acc_n;
    logic       par_ok, par_ok_n;
    logic       push;
    logic       perr_n, ferr_n;
    logic       timeout_hit;

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer;

    assign timeout_hit = (state != IDLE) && !fall && (timer == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (state == IDLE || fall || timeout_hit) begin
            timer <= '0;
        end else begin
            timer <= timer + TW'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            par_acc    <= 1'b0;
            par_ok     <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            par_acc    <= par_acc_n;
            par_ok     <= par_ok_n;
            parity_err <= perr_n;
            frame_err  <= ferr_n;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        par_acc_n = par_acc;
        par_ok_n  = par_ok;
        push      = 1'b0;
        perr_n    = 1'b0;
        ferr_n    = 1'b0;
        if (fall) begin
            unique case (state)
                IDLE: begin
                    if (!data_s) begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                        par_acc_n = 1'b0;
                    end
                end
                DATA: begin
                    shift_n   = {data_s, shift[7:1]};
                    par_acc_n = par_acc ^ data_s;
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = PARITY;
                end
                PARITY: begin
                    par_ok_n = par_acc ^ data_s;
                    state_n  = STOP;
                end
                STOP: begin
                    if (!data_s)     ferr_n = 1'b1;
                    else if (par_ok) push   = 1'b1;
                    else             perr_n = 1'b1;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end else if (timeout_hit) begin
            state_n = IDLE;
            ferr_n  = 1'b1;
        end
    end

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty, pop, wr;

    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign pop   = rd_en & ~empty;
    assign wr    = push & (~full | pop);

    // NOTE: the storage array has no reset; emptiness is tracked by count, so stale data is never visible.
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= shift;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            unique case ({wr, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (pop)                 overflow <= 1'b0;
            else if (push && full)   overflow <= 1'b1;
        end
    end

    assign rd_valid   = ~empty;
    assign rd_data    = empty ? 8'h00 : mem[rd_ptr];
    assign fifo_count = count;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: good/bad frames, FIFO overflow, mid-frame reset and,
// when PS2_RX_TIMEOUT_EN is defined, the stalled-frame timeout.
module tb_ps2_rx_fifo;

    localparam int SYNC    = 2;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 200;
    localparam int HALF    = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [2:0] fifo_count;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;

    int checks = 0;
    int failures = 0;
    int perr_total = 0;
    int ferr_total = 0;
    int perr_base;
    int ferr_base;

    ps2_rx_fifo #(
        .SYNC_STAGES   (SYNC),
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .fifo_count(fifo_count),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (parity_err) perr_total++;
        if (frame_err)  ferr_total++;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        wait_cycles(HALF);
        ps2_clk = 1'b0;
        wait_cycles(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stop);
        ps2_data = 1'b1;
        wait_cycles(HALF);
    endtask

    task automatic send_good(input logic [7:0] d);
        send_frame(d, ~^d, 1'b1);
    endtask

    task automatic pop_one;
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic mark_errs;
        perr_base = perr_total;
        ferr_base = ferr_total;
    endtask

    initial begin
        logic [7:0] exp_byte;

        wait_cycles(3);
        check("reset_count", 32'(fifo_count), 32'd0);
        check("reset_valid", 32'(rd_valid), 32'd0);
        check("reset_data", 32'(rd_data), 32'h00);
        check("reset_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        wait_cycles(3);

        // Valid 0x1C frame (parity 0)
        mark_errs();
        send_frame(8'h1C, 1'b0, 1'b1);
        check("good_valid", 32'(rd_valid), 32'd1);
        check("good_data", 32'(rd_data), 32'h1C);
        check("good_count", 32'(fifo_count), 32'd1);
        check("good_perr", 32'(perr_total - perr_base), 32'd0);
        check("good_ferr", 32'(ferr_total - ferr_base), 32'd0);
        pop_one();
        check("pop_empty", 32'(fifo_count), 32'd0);

        // Bad parity
        mark_errs();
        send_frame(8'h1C, 1'b1, 1'b1);
        check("perr_pulse", 32'(perr_total - perr_base), 32'd1);
        check("perr_ferr", 32'(ferr_total - ferr_base), 32'd0);
        check("perr_count", 32'(fifo_count), 32'd0);

        // Bad stop bit
        mark_errs();
        send_frame(8'hF0, 1'b1, 1'b0);
        check("ferr_pulse", 32'(ferr_total - ferr_base), 32'd1);
        check("ferr_perr", 32'(perr_total - perr_base), 32'd0);
        check("ferr_count", 32'(fifo_count), 32'd0);

        // Overflow: five frames into a four-deep FIFO
        for (int i = 1; i <= 5; i++) send_good(8'(i));
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_count", 32'(fifo_count), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            exp_byte = 8'(i);
            check($sformatf("ovf_pop%0d", i), 32'(rd_data), 32'(exp_byte));
            pop_one();
            check($sformatf("ovf_clear%0d", i), 32'(overflow), 32'd0);
        end
        check("ovf_drained", 32'(rd_valid), 32'd0);

        // rd_en while empty is ignored
        pop_one();
        check("empty_pop", 32'(fifo_count), 32'd0);

        // Mid-frame reset: one byte buffered, then 5 bits of a new frame
        send_good(8'hA5);
        check("pre_rst_count", 32'(fifo_count), 32'd1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_data", 32'(rd_data), 32'h00);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_errs", 32'({parity_err, frame_err}), 32'd0);
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(3);
        mark_errs();
        send_frame(8'h1C, 1'b0, 1'b1);
        check("post_rst_count", 32'(fifo_count), 32'd1);
        check("post_rst_data", 32'(rd_data), 32'h1C);
        check("post_rst_errs", 32'((perr_total - perr_base) + (ferr_total - ferr_base)), 32'd0);
        pop_one();

`ifdef PS2_RX_TIMEOUT_EN
        mark_errs();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        ps2_data = 1'b1;
        wait_cycles(TIMEOUT + SYNC + 2);
        check("tmo_ferr", 32'(ferr_total - ferr_base), 32'd1);
        check("tmo_count", 32'(fifo_count), 32'd0);
        mark_errs();
        send_frame(8'hF0, 1'b1, 1'b1);
        check("tmo_next_data", 32'(rd_data), 32'hF0);
        check("tmo_next_count", 32'(fifo_count), 32'd1);
        check("tmo_next_errs", 32'((perr_total - perr_base) + (ferr_total - ferr_base)), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchroniser depth on ps2_clk/ps2_data; legal range 2..4.
REQ-002 Parameter FIFO_DEPTH, default 8: received-byte buffer entries; power of two, at least 2.
REQ-003 Parameter TIMEOUT_CYCLES, default 100000: clk cycles without a PS/2 falling edge before a partial frame is aborted (2 ms at 50 MHz).
REQ-004 clk  input  1  system clock; the only clock in the block.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk.
REQ-007 ps2_data  input  1  raw PS/2 data line, asynchronous to clk.
REQ-008 rd_en  input  1  pop request for the FIFO head.
REQ-009 rd_data  output  8  FIFO head byte, first-word-fall-through.
REQ-010 rd_valid  output  1  FIFO non-empty.
REQ-011 fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.
REQ-012 parity_err  output  1  one-cycle pulse on a parity failure.
REQ-013 frame_err  output  1  one-cycle pulse on a bad stop bit or a timeout abort.
REQ-014 overflow  output  1  sticky flag: a completed byte was dropped because the FIFO was full.

Function
REQ-015 Both PS/2 inputs SHALL pass through SYNC_STAGES clk flops; a falling edge is synced ps2_clk 1 on the previous cycle and 0 on the current cycle.
REQ-016 All frame FSM activity SHALL occur only on cycles carrying a falling edge; ps2_data is sampled from the synchronised value on that cycle.
REQ-017 FSM states IDLE, DATA, PARITY, STOP. IDLE goes to DATA on an edge with data=0 (start bit), clearing the bit counter and parity accumulator; an edge with data=1 keeps IDLE.
REQ-018 DATA SHALL shift 8 bits LSB first, accumulating XOR; after the 8th bit -> PARITY.
REQ-019 PARITY SHALL record parity_ok = (XOR of data bits ^ parity bit) == 1 (odd parity); -> STOP.
REQ-020 STOP with data=1 and parity_ok pushes the byte; with data=1 and !parity_ok pulses parity_err, no push; with data=0 pulses frame_err, no push; all cases -> IDLE.
REQ-021 Pushed byte SHALL appear on rd_data with rd_valid=1 the clk cycle after the stop-bit edge cycle.
REQ-022 rd_en with rd_valid=1 pops the head on that cycle; rd_en with rd_valid=0 is ignored.
REQ-023 Push when full and no pop: byte dropped, FIFO contents unchanged, overflow set.
REQ-024 Simultaneous push and pop when full: both take effect, count unchanged, overflow not set.
REQ-025 Simultaneous push and rd_en when empty: push succeeds, rd_en ignored, count becomes 1.
REQ-026 overflow SHALL clear on the first accepted pop after it was set, or on reset.
REQ-027 Read/write pointers SHALL wrap modulo FIFO_DEPTH; fifo_count never exceeds FIFO_DEPTH.

Reset
REQ-028 rst_n low SHALL immediately force: FSM IDLE, counters and timer 0, FIFO empty, rd_valid 0, fifo_count 0, rd_data 0x00, parity_err 0, frame_err 0, overflow 0, synchroniser flops 1 (line idle).
REQ-029 Reset mid-frame SHALL discard the partial frame; the first edge after release is treated from IDLE.

Configuration
REQ-030 Macro PS2_RX_TIMEOUT_EN defined: in any non-IDLE state, TIMEOUT_CYCLES consecutive clk cycles without a falling edge SHALL abort to IDLE with a frame_err pulse, no push; the timer restarts on every edge.
REQ-031 Macro PS2_RX_TIMEOUT_EN undefined: no timer logic; a partial frame waits indefinitely for further edges.

Verification
REQ-032 Frame 0x1C, parity 0, stop 1 -> rd_valid=1, rd_data=0x1C, fifo_count=1, no error pulses.
REQ-033 Frame 0x1C with parity 1 -> one parity_err pulse, fifo_count stays 0.
REQ-034 Frame 0xF0, parity 1, stop 0 -> one frame_err pulse, nothing pushed.
REQ-035 FIFO_DEPTH=4, five valid frames 0x01..0x05, no reads -> overflow=1, pops return 0x01..0x04, overflow clears on first pop.
REQ-036 With PS2_RX_TIMEOUT_EN: start bit plus 3 data bits, then idle TIMEOUT_CYCLES+SYNC_STAGES+2 cycles -> one frame_err pulse; next frame 0xF0 (parity 1) received intact.
REQ-037 rst_n pulsed low after 5 bits of a frame -> outputs at reset values; a following 0x1C frame is received correctly.
